seq_alu: RTL
============

# seq_alu

Parametrised, handshaked successor to the team's combinational 32-bit ALU. It keeps the eight existing 4-bit opcodes and adds shifts and an iterative multiply. Operands enter on a valid/ready input port, and results leave on a registered valid/ready output port together with a full flag set. It sits between the operand-fetch stage and write-back.

## Interface
- WIDTH, 32, operand/result width; ≥2.
- SHW, $clog2(WIDTH), derived; shift-amount bits taken from op2.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept this cycle.
- op1, op2  in  WIDTH  operands.
- alu_control  in  4  opcode.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero, neg, carry, ovf, err  out  1 each  registered flags.

## Operation
- Opcodes:
  - 0000 ~op1
  - 0001 AND
  - 0010 XOR
  - 0011 OR
  - 0100 op1-1
  - 0101 op1+op2
  - 0110 op1-op2
  - 0111 op1+1
  - 1000 SHL
  - 1001 SHR logical
  - 1010 SAR
  - 1011 MUL (low WIDTH bits of unsigned product)
  - 1100–1111 illegal
- Shifts use op2[SHW-1:0] as the amount; upper op2 bits are ignored.
- Arithmetic wraps modulo 2^WIDTH. Ops 0100–0111 are computed at WIDTH+1 bits for flags.
- zero = (result==0); neg = result[WIDTH-1].
- carry:
  - ADD/INC: carry-out.
  - SUB/DEC: borrow, i.e. op1 < subtrahend unsigned.
  - MUL: upper product half nonzero.
  - Otherwise 0.
- ovf: signed overflow for ADD/SUB/INC/DEC; 0 otherwise.
- Illegal opcode: result=0, zero=1, err=1, other flags 0, single-cycle latency. err=0 for all legal ops.
- FSM states:
  - IDLE: in_ready=1. An accepted MUL goes to BUSY; any other accepted op goes to DONE.
  - BUSY: shift-add, one op2 bit per cycle, counter 0..WIDTH-1. Goes to DONE after the WIDTH-th iteration.
  - DONE: out_valid=1 and outputs held stable. On out_ready: if in_valid and the new op is not MUL, load the new result and stay in DONE; if MUL, go to BUSY; otherwise go to IDLE.
- in_ready = IDLE, or (DONE and out_ready). It is 0 throughout BUSY.
- Operands are captured on acceptance. Input changes after the handshake have no effect.

## Timing
- Reset (synchronous) values: state=IDLE, in_ready=1 on the following cycle, out_valid=0, result=0, all flags 0, multiply counter/accumulator 0.
- Reset during BUSY or DONE aborts the operation and discards the result. No out_valid pulse follows.
- Non-MUL latency: accepted at edge N, out_valid=1 after edge N+1.
- MUL latency: WIDTH+1 edges from acceptance to out_valid.
- Throughput:
  - Non-MUL: 1 op/cycle while out_ready is held high (back-to-back accept in DONE).
  - MUL: 1 per WIDTH+1 cycles.
- Backpressure: with out_ready=0 in DONE, result and flags hold indefinitely and in_ready=0.
- in_valid with in_ready=0: no capture. The producer must hold its values.

## Configuration
- SEQ_ALU_MUL_EN defined: opcode 1011 is the iterative multiplier, and BUSY exists.
- SEQ_ALU_MUL_EN undefined: no multiplier logic. 1011 is treated as illegal (err=1, single-cycle), and BUSY is never entered.

## Structure
- Package seq_alu_pkg contains:
  - opcode localparams OP_COMPLEMENT … OP_MUL.
  - a state enum (IDLE/BUSY/DONE).
  - a flags struct {zero, neg, carry, ovf, err}.
- Sub-module seq_alu_mul, instantiated only under SEQ_ALU_MUL_EN:
  - interface: start, op1, op2 → done, product[2*WIDTH-1:0].
  - implementation: iterative shift-add with a $clog2(WIDTH+1)-bit counter.
- The top level holds the FSM, the combinational op decode and the output registers.

## Test plan
- WIDTH=32, ADD 0xFFFFFFFF+1 → result 0, zero=1, carry=1, ovf=0, out_valid one cycle after accept.
- SUB 0x80000000-1 → 0x7FFFFFFF, ovf=1, carry=0, neg=0; DEC of 0 → 0xFFFFFFFF, carry=1, neg=1.
- SAR 0x80000000 by op2=0x00000024 (amount 4) → 0xF8000000; SHR same → 0x08000000.
- MUL 0x00010000×0x00010000 → result 0, carry=1, out_valid exactly 33 edges after accept, in_ready=0 during BUSY. Repeat with the macro undefined → err=1, 1-cycle latency.
- Back-to-back AND/OR/XOR with out_ready=1 → one result per cycle. Drop out_ready for 3 cycles → outputs stable, in_ready=0.
- Assert rst mid-MUL (cycle 10) → next cycle out_valid=0, result=0, in_ready=1; opcode 1111 afterwards → err=1, zero=1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   - 4-bit opcode constants OP_COMPLEMENT .. OP_MUL
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - result flag bundle {zero, neg, carry, ovf, err}
package seq_alu_pkg;

    localparam logic [3:0] OP_COMPLEMENT = 4'b0000;
    localparam logic [3:0] OP_AND        = 4'b0001;
    localparam logic [3:0] OP_XOR        = 4'b0010;
    localparam logic [3:0] OP_OR         = 4'b0011;
    localparam logic [3:0] OP_DEC        = 4'b0100;
    localparam logic [3:0] OP_ADD        = 4'b0101;
    localparam logic [3:0] OP_SUB        = 4'b0110;
    localparam logic [3:0] OP_INC        = 4'b0111;
    localparam logic [3:0] OP_SHL        = 4'b1000;
    localparam logic [3:0] OP_SHR        = 4'b1001;
    localparam logic [3:0] OP_SAR        = 4'b1010;
    localparam logic [3:0] OP_MUL        = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic err;
    } flags_t;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-add unsigned multiplier, one op2 bit per cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load op1/op2 and begin (ignored while no operation runs is fine)
//   op1, op2        WIDTH-bit unsigned operands, sampled on start
//   done            high during the cycle of the final (WIDTH-th) iteration
//   product         2*WIDTH-bit product; valid while done is high
// The product is presented combinationally from the last iteration step so
// the caller can register it on the same edge that completes the multiply.
module seq_alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]        cnt_r;
    logic                 active_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   step_s;

    assign step_s  = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    assign done    = active_r & (cnt_r == CW'(WIDTH - 1));
    assign product = step_s;

    // Operand load on start, then one shift-add iteration per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {CW{1'b0}};
            active_r <= 1'b0;
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
        end else if (start) begin
            cnt_r    <= {CW{1'b0}};
            active_r <= 1'b1;
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, op1};
            mplier_r <= op2;
        end else if (active_r) begin
            acc_r    <= step_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            if (cnt_r == CW'(WIDTH - 1)) begin
                active_r <= 1'b0;
                cnt_r    <= {CW{1'b0}};
            end else begin
                cnt_r    <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU with registered result and flags.
// Optional feature macro: SEQ_ALU_MUL_EN (iterative multiply on opcode 1011;
// when undefined, 1011 is illegal and BUSY is never entered).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand handshake (op1, op2, alu_control)
//   out_valid / out_ready    result handshake (result, zero, neg, carry, ovf, err)
// Non-multiply results are computed combinationally from the inputs and
// registered on the accepting edge; multiplies run in seq_alu_mul.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    input  logic [3:0]        alu_control,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              neg,
    output logic              carry,
    output logic              ovf,
    output logic              err
);

    localparam int SHW = $clog2(WIDTH);

    state_e               state_r;
    state_e               state_next_s;
    logic [WIDTH-1:0]     result_r;
    flags_t               flags_r;

    logic [WIDTH-1:0]     alu_res_s;
    flags_t               alu_flags_s;
    logic [WIDTH:0]       ext_s;
    logic [SHW-1:0]       shamt_s;

    logic                 is_mul_s;
    logic                 mul_start_s;
    logic                 mul_done_s;
    logic [2*WIDTH-1:0]   mul_product_s;
    logic                 load_alu_s;
    logic                 load_mul_s;

    assign shamt_s     = op2[SHW-1:0];
    assign in_ready    = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    assign mul_start_s = in_valid & in_ready & is_mul_s;

`ifdef SEQ_ALU_MUL_EN
    assign is_mul_s = (alu_control == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .op1     (op1),
        .op2     (op2),
        .done    (mul_done_s),
        .product (mul_product_s)
    );
`else
    assign is_mul_s      = 1'b0;
    assign mul_done_s    = 1'b0;
    assign mul_product_s = {(2*WIDTH){1'b0}};
`endif

    // Single-cycle opcode decode; the ext_s MSB is carry-out / borrow.
    always_comb begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_flags_s = 5'b00000;
        ext_s       = {(WIDTH+1){1'b0}};
        case (alu_control)
            OP_COMPLEMENT: alu_res_s = ~op1;
            OP_AND:        alu_res_s = op1 & op2;
            OP_XOR:        alu_res_s = op1 ^ op2;
            OP_OR:         alu_res_s = op1 | op2;
            OP_DEC: begin
                ext_s             = {1'b0, op1} - {{WIDTH{1'b0}}, 1'b1};
                alu_res_s         = ext_s[WIDTH-1:0];
                alu_flags_s.carry = ext_s[WIDTH];
                alu_flags_s.ovf   = op1[WIDTH-1] & ~ext_s[WIDTH-1];
            end
            OP_ADD: begin
                ext_s             = {1'b0, op1} + {1'b0, op2};
                alu_res_s         = ext_s[WIDTH-1:0];
                alu_flags_s.carry = ext_s[WIDTH];
                alu_flags_s.ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) &
                                    (ext_s[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                ext_s             = {1'b0, op1} - {1'b0, op2};
                alu_res_s         = ext_s[WIDTH-1:0];
                alu_flags_s.carry = ext_s[WIDTH];
                alu_flags_s.ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) &
                                    (ext_s[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_INC: begin
                ext_s             = {1'b0, op1} + {{WIDTH{1'b0}}, 1'b1};
                alu_res_s         = ext_s[WIDTH-1:0];
                alu_flags_s.carry = ext_s[WIDTH];
                alu_flags_s.ovf   = ~op1[WIDTH-1] & ext_s[WIDTH-1];
            end
            OP_SHL:        alu_res_s = op1 << shamt_s;
            OP_SHR:        alu_res_s = op1 >> shamt_s;
            OP_SAR:        alu_res_s = $signed(op1) >>> shamt_s;
`ifdef SEQ_ALU_MUL_EN
            // Result comes from the multiplier; this path is never loaded.
            OP_MUL:        alu_res_s = {WIDTH{1'b0}};
`endif
            default:       alu_flags_s.err = 1'b1;
        endcase
        alu_flags_s.zero = ~|alu_res_s;
        alu_flags_s.neg  = alu_res_s[WIDTH-1];
    end

    // Next-state and register-load decode.
    always_comb begin
        state_next_s = state_r;
        load_alu_s   = 1'b0;
        load_mul_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (is_mul_s) begin
                        state_next_s = BUSY;
                    end else begin
                        state_next_s = DONE;
                        load_alu_s   = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (mul_done_s) begin
                    state_next_s = DONE;
                    load_mul_s   = 1'b1;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        if (is_mul_s) begin
                            state_next_s = BUSY;
                        end else begin
                            state_next_s = DONE;
                            load_alu_s   = 1'b1;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            result_r <= {WIDTH{1'b0}};
            flags_r  <= 5'b00000;
        end else begin
            state_r <= state_next_s;
            if (load_alu_s) begin
                result_r <= alu_res_s;
                flags_r  <= alu_flags_s;
            end else if (load_mul_s) begin
                result_r      <= mul_product_s[WIDTH-1:0];
                flags_r.zero  <= ~|mul_product_s[WIDTH-1:0];
                flags_r.neg   <= mul_product_s[WIDTH-1];
                flags_r.carry <= |mul_product_s[2*WIDTH-1:WIDTH];
                flags_r.ovf   <= 1'b0;
                flags_r.err   <= 1'b0;
            end
        end
    end

    assign out_valid = (state_r == DONE);
    assign result    = result_r;
    assign zero      = flags_r.zero;
    assign neg       = flags_r.neg;
    assign carry     = flags_r.carry;
    assign ovf       = flags_r.ovf;
    assign err       = flags_r.err;

endmodule
